// File: rtl/ysyx_25060170_pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/flush controller: FSM encodings,
// register x0 address, reset active level and default CSR drain length.
package ysyx_25060170_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MEM_WAIT  = 2'd1,
    ST_CSR_DRAIN = 2'd2
  } pipe_state_e;

  localparam logic [4:0] REG_X0            = 5'd0;
  localparam logic       RST_ACTIVE        = 1'b0;
  localparam int         CSR_DRAIN_CYC_DEF = 2;

endpackage

// File: rtl/ysyx_25060170_hazard_det.sv
// Combinational load-use detector: a load in EX whose rd feeds a source of the
// instruction in ID. Writes to x0 never create a hazard.
module ysyx_25060170_hazard_det
  import ysyx_25060170_pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic       ex_load_flag,
  input  logic       ex_rd_ena,
  input  logic [4:0] ex_rd_addr,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_rs1_used & (id_rs1_addr == ex_rd_addr);
  assign rs2_hit  = id_rs2_used & (id_rs2_addr == ex_rd_addr);
  assign load_use = ex_load_flag & ex_rd_ena & (ex_rd_addr != REG_X0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/ysyx_25060170_pipe_ctrl.sv
// Pipeline hazard and flush controller: RUN / MEM_WAIT / CSR_DRAIN sequencer with
// a combinational priority mux. Define YSYX_25060170_PERF_EN for stall/flush counters.
module ysyx_25060170_pipe_ctrl
  import ysyx_25060170_pipe_ctrl_pkg::*;
#(
  parameter int CSR_DRAIN_CYC = CSR_DRAIN_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic        id_csr_ena,
  input  logic        ex_load_flag,
  input  logic        ex_rd_ena,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_redirect,
  input  logic        ex_busy,
  input  logic        ls_req,
  input  logic        ls_resp,
  input  logic        ls_trap,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_stall,
  output logic        exls_stall,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exls_flush,
`ifdef YSYX_25060170_PERF_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
`endif
  output pipe_state_e dbg_state
);

  // Handshake: none; every output is a level for the current cycle, derived
  // from registered state plus this cycle's inputs, and sampled by the stage
  // registers at the next posedge clk.

  pipe_state_e state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        load_use;
  logic        mem_hold;

  ysyx_25060170_hazard_det u_hazard_det (
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .ex_load_flag (ex_load_flag),
    .ex_rd_ena    (ex_rd_ena),
    .ex_rd_addr   (ex_rd_addr),
    .load_use     (load_use)
  );

  assign mem_hold = !ls_resp & ((state_q == ST_MEM_WAIT) | ((state_q == ST_RUN) & ls_req));

  always_comb begin
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    idex_stall = 1'b0;
    exls_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    exls_flush = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    if (rst == RST_ACTIVE) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      exls_flush = 1'b1;
      state_d    = ST_RUN;
      cnt_d      = 2'd0;
    end else if (ls_trap) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      exls_flush = 1'b1;
      state_d    = ST_RUN;
      cnt_d      = 2'd0;
    end else if (mem_hold) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_stall = 1'b1;
      exls_stall = 1'b1;
      state_d    = ST_MEM_WAIT;
    end else begin
      // The response cycle of MEM_WAIT behaves as an ordinary RUN cycle.
      if (state_q == ST_MEM_WAIT) state_d = ST_RUN;
      if (ex_redirect) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        state_d    = ST_RUN;
        cnt_d      = 2'd0;
      end else if (ex_busy) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_stall = 1'b1;
        exls_flush = 1'b1;
      end else if (state_q == ST_CSR_DRAIN) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
        if (cnt_q <= 2'd1) begin
          state_d = ST_RUN;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end else if (id_csr_ena & (ex_rd_ena | ex_load_flag | ls_req)) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
        // The entry cycle is the first drain cycle; a 1-cycle drain needs no state.
        if (CSR_DRAIN_CYC > 1) begin
          state_d = ST_CSR_DRAIN;
          cnt_d   = 2'(CSR_DRAIN_CYC - 1);
        end
      end else if (load_use) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      state_q <= ST_RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dbg_state = state_q;

`ifdef YSYX_25060170_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (pc_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (ifid_flush | idex_flush | exls_flush) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_25060170_pipe_ctrl.sv
// Directed bench for ysyx_25060170_pipe_ctrl; output vector is
// {pc,ifid,idex,exls stall, ifid,idex,exls flush}.
module tb_ysyx_25060170_pipe_ctrl;
  import ysyx_25060170_pipe_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1_addr, id_rs2_addr;
  logic        id_rs1_used, id_rs2_used, id_csr_ena;
  logic        ex_load_flag, ex_rd_ena;
  logic [4:0]  ex_rd_addr;
  logic        ex_redirect, ex_busy, ls_req, ls_resp, ls_trap;
  logic        pc_stall, ifid_stall, idex_stall, exls_stall;
  logic        ifid_flush, idex_flush, exls_flush;
  pipe_state_e dbg_state;
`ifdef YSYX_25060170_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] O_IDLE = 7'b0000_000;
  localparam logic [6:0] O_HOLD = 7'b1111_000;
  localparam logic [6:0] O_BUBL = 7'b1100_010;
  localparam logic [6:0] O_REDR = 7'b0000_110;
  localparam logic [6:0] O_FLSH = 7'b0000_111;
  localparam logic [6:0] O_BUSY = 7'b1110_001;

  ysyx_25060170_pipe_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_csr_ena   (id_csr_ena),
    .ex_load_flag (ex_load_flag),
    .ex_rd_ena    (ex_rd_ena),
    .ex_rd_addr   (ex_rd_addr),
    .ex_redirect  (ex_redirect),
    .ex_busy      (ex_busy),
    .ls_req       (ls_req),
    .ls_resp      (ls_resp),
    .ls_trap      (ls_trap),
    .pc_stall     (pc_stall),
    .ifid_stall   (ifid_stall),
    .idex_stall   (idex_stall),
    .exls_stall   (exls_stall),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exls_flush   (exls_flush),
`ifdef YSYX_25060170_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
`endif
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({pc_stall, ifid_stall, idex_stall, exls_stall, ifid_flush, idex_flush, exls_flush});
  endfunction

  // driver tasks
  task automatic idle();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    id_csr_ena = 1'b0; ex_load_flag = 1'b0; ex_rd_ena = 1'b0; ex_rd_addr = 5'd0;
    ex_redirect = 1'b0; ex_busy = 1'b0; ls_req = 1'b0; ls_resp = 1'b0; ls_trap = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_in_ex(input logic [4:0] rd);
    ex_load_flag = 1'b1; ex_rd_ena = 1'b1; ex_rd_addr = rd;
  endtask

  task automatic chk_out(input string tag, input logic [6:0] exp);
    #2;
    check(tag, outs(), 32'(exp));
  endtask

  task automatic chk_st(input string tag, input pipe_state_e exp);
    check(tag, 32'(dbg_state), 32'(exp));
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #3;
    check("reset_outs", outs(), 32'(O_FLSH));
    chk_st("reset_state", ST_RUN);
    tick();
    rst = 1'b1;
    chk_out("idle", O_IDLE);

    // load-use on rs2, on rs1, and the non-hazard variants
    tick(); load_in_ex(5'd5); id_rs2_addr = 5'd5; id_rs2_used = 1'b1;
    chk_out("lu_rs2", O_BUBL);
    tick(); chk_st("lu_state", ST_RUN);
    idle(); load_in_ex(5'd0); id_rs2_used = 1'b1;
    chk_out("lu_x0", O_IDLE);
    tick(); idle(); load_in_ex(5'd7); id_rs1_addr = 5'd7; id_rs1_used = 1'b1;
    chk_out("lu_rs1", O_BUBL);
    tick(); idle(); load_in_ex(5'd7); id_rs2_addr = 5'd7;
    chk_out("lu_unused", O_IDLE);

    // memory wait for 3 cycles, released in the response cycle
    tick(); idle(); ls_req = 1'b1;
    chk_out("mw_c0", O_HOLD);
    tick(); chk_st("mw_state", ST_MEM_WAIT);
    chk_out("mw_c1", O_HOLD);
    tick(); chk_out("mw_c2", O_HOLD);
    tick(); ls_resp = 1'b1;
    chk_out("mw_resp", O_IDLE);
    tick(); idle(); chk_st("mw_exit", ST_RUN);

    // redirect overrides load-use; busy
    load_in_ex(5'd3); id_rs1_addr = 5'd3; id_rs1_used = 1'b1; ex_redirect = 1'b1;
    chk_out("redir_lu", O_REDR);
    tick(); idle(); ex_busy = 1'b1;
    chk_out("busy", O_BUSY);

    // CSR drain of 2 cycles
    tick(); idle(); id_csr_ena = 1'b1; ex_rd_ena = 1'b1;
    chk_out("csr_c0", O_BUBL);
    tick(); chk_st("csr_state", ST_CSR_DRAIN);
    ex_rd_ena = 1'b0;
    chk_out("csr_c1", O_BUBL);
    tick(); chk_st("csr_exit", ST_RUN);
    chk_out("csr_rel", O_IDLE);

    // trap during MEM_WAIT, with a simultaneous response
    tick(); idle(); ls_req = 1'b1;
    tick(); chk_st("tr_mw", ST_MEM_WAIT);
    ls_trap = 1'b1; ls_resp = 1'b1;
    chk_out("trap", O_FLSH);
    tick(); idle(); chk_st("trap_state", ST_RUN);
    chk_out("trap_after", O_IDLE);

    // redirect held through MEM_WAIT
    tick(); ls_req = 1'b1;
    tick(); ex_redirect = 1'b1;
    chk_out("redir_mw", O_HOLD);
    tick(); ls_resp = 1'b1;
    chk_out("redir_resp", O_REDR);

    // asynchronous reset in the middle of CSR_DRAIN
    tick(); idle(); id_csr_ena = 1'b1; ex_load_flag = 1'b1;
    tick(); chk_st("rc_state", ST_CSR_DRAIN);
    #2 rst = 1'b0;
    #1;
    check("rc_outs", outs(), 32'(O_FLSH));
    chk_st("rc_run", ST_RUN);
    tick(); rst = 1'b1; idle();
    chk_out("rc_idle", O_IDLE);

`ifdef YSYX_25060170_PERF_EN
    // 2 hold cycles + 3 bubble cycles: 5 stalls, 3 flushes since reset
    rst = 1'b0; #1 rst = 1'b1;
    ls_req = 1'b1;
    tick(); tick(); ls_resp = 1'b1;
    tick(); idle(); load_in_ex(5'd9); id_rs2_addr = 5'd9; id_rs2_used = 1'b1;
    tick(); tick(); tick(); idle();
    #2;
    check("perf_stall", perf_stall_cnt, 32'd5);
    check("perf_flush", perf_flush_cnt, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_25060170_pipe_ctrl.md
# ysyx_25060170_pipe_ctrl

Central hazard and flush controller for the five-stage NPC pipeline. It drives the hold and flush inputs of every inter-stage register (IF/ID, ID/EX, EX/LS) and the PC hold. It sits between decode, execute and load/store and resolves load-use hazards, memory wait states, EX redirects, multi-cycle EX operations, CSR serialisation and LS-stage traps. It owns the small FSM that sequences these; stall and flush outputs are combinational from FSM state plus current inputs.

## Interface
- CSR_DRAIN_CYC, 2, cycles a CSR instruction waits in ID for older instructions to drain from EX/LS (1..3)
- clk  input  1  pipeline clock
- rst  input  1  asynchronous, active-low reset
- id_rs1_addr, id_rs2_addr  input  5 each  source registers of the instruction in ID
- id_rs1_used, id_rs2_used  input  1 each  ID instruction reads rs1/rs2
- id_csr_ena  input  1  ID instruction is a CSR access
- ex_load_flag  input  1  EX holds a load
- ex_rd_ena  input  1  EX writes rd
- ex_rd_addr  input  5  EX destination
- ex_redirect  input  1  EX resolved a taken branch/jump; held by EX while EX is stalled
- ex_busy  input  1  multi-cycle EX op not finished
- ls_req  input  1  LS issuing/holding a memory request
- ls_resp  input  1  memory response for the LS request (1-cycle pulse)
- ls_trap  input  1  exception/mret/ecall resolved in LS
- pc_stall, ifid_stall, idex_stall, exls_stall  output  1 each  hold stage register
- ifid_flush, idex_flush, exls_flush  output  1 each  load bubble into stage register
- perf_stall_cnt, perf_flush_cnt  output  32 each  (only with YSYX_25060170_PERF_EN)

## Operation
- FSM states: RUN, MEM_WAIT, CSR_DRAIN. Reset state RUN, drain counter 0.
- Priority per cycle, highest first:
  1. ls_trap: ifid/idex/exls_flush=1, all stalls 0; FSM→RUN, counter cleared (aborts MEM_WAIT and CSR_DRAIN).
  2. MEM_WAIT, or RUN with ls_req & !ls_resp: pc/ifid/idex/exls_stall=1; no flush. RUN→MEM_WAIT; MEM_WAIT→RUN in the cycle ls_resp=1 (stalls deasserted that cycle).
  3. ex_redirect: ifid_flush=idex_flush=1; stalls 0. Overrides load-use and CSR_DRAIN (FSM→RUN).
  4. ex_busy: pc/ifid/idex_stall=1, exls_flush=1.
  5. CSR_DRAIN: pc/ifid_stall=1, idex_flush=1; counter decrements; →RUN after it reaches 0 (exit cycle itself releases stalls).
  6. RUN, id_csr_ena and (EX or LS non-empty, i.e. ex_rd_ena|ex_load_flag|ls_req): enter CSR_DRAIN, counter←CSR_DRAIN_CYC-1, same outputs as 5.
  7. Load-use: ex_load_flag & ex_rd_ena & ex_rd_addr≠0 & ((id_rs1_used & rs1==rd)|(id_rs2_used & rs2==rd)): pc/ifid_stall=1, idex_flush=1, one cycle, no state change.
  8. Otherwise all outputs 0.
- A stage never has stall and flush both asserted.
- rd=x0 never creates a load-use hazard.

## Timing
- While rst low: all stalls 0, all flushes 1, FSM RUN, perf counters 0.
- All outputs combinational; zero-cycle latency from inputs. State and counters update on posedge clk.
- Load-use bubble exactly 1 cycle; if the load then waits in LS, MEM_WAIT extends the stall until ls_resp.
- ls_resp and ls_trap in the same cycle: trap wins, FSM→RUN.
- ex_redirect during MEM_WAIT is ignored; it is honoured in the first non-stalled cycle (EX holds it).
- Reset asserted mid-MEM_WAIT or mid-CSR_DRAIN: immediate return to RUN and reset outputs.

## Configuration
- YSYX_25060170_PERF_EN defined: perf_stall_cnt increments in every cycle pc_stall=1; perf_flush_cnt increments in every cycle any flush=1 outside reset; both wrap at 2^32; ports present.
- Undefined: counters and ports absent; control behaviour identical.

## Structure
- Shared define file: FSM state encodings (2-bit), x0 address constant, RSTABLE level for this block, CSR_DRAIN_CYC default.
- Sub-module ysyx_25060170_hazard_det: pure combinational load-use comparator (7).
- FSM, priority mux and perf counters in the top module.

## Test plan
- Load x5 in EX, ID uses rs2=x5 → pc/ifid_stall=1, idex_flush=1 for one cycle; rd=x0 → no stall.
- ls_req=1, ls_resp after 3 cycles → all four stalls for 3 cycles, released in the ls_resp cycle, FSM RUN.
- ex_redirect with a simultaneous load-use → only ifid/idex_flush=1, no stall.
- CSR in ID with EX non-empty, CSR_DRAIN_CYC=2 → 2 cycles of pc/ifid_stall + idex_flush, then release.
- ls_trap during MEM_WAIT → all three flushes, stalls 0, FSM RUN next cycle.
- With PERF_EN: 5 stall cycles and 3 flush cycles → counters 5 and 3; preset 0xFFFFFFFF + 1 stall → 0.
